fetch_ctrl: RTL and testbench

//  Sequences instruction fetch for the 5-stage core: owns the PC, issues one

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the instruction fetch controller.
`default_nettype none

package fetch_ctrl_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, keeps one imem request in flight,
// and hands fetched words to IF/ID through a one-entry valid/ready slot.
`default_nettype none

module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         kill_q;
    logic         fire;
    logic         resp;
    logic         load;

    // Only request when the slot is empty or being drained this cycle, so a
    // returning word can never land on an unconsumed instruction.
    assign imem_req_o  = (state == REQ) && (!if_valid_o || if_ready_i);
    assign imem_addr_o = (state == REQ) ? pc_q : 32'h0000_0000;
    assign fire        = imem_req_o && imem_gnt_i;
    assign resp        = (state == WAIT) && imem_rvalid_i;
    assign load        = resp && !kill_q && !redirect_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= 32'h0000_0000;
            kill_q     <= 1'b0;
            if_valid_o <= 1'b0;
            if_inst_o  <= NOP_INST;
            if_pc_o    <= 32'h0000_0000;
        end else begin
            if (if_valid_o && if_ready_i) begin
                if_valid_o <= 1'b0;
            end

            case (state)
                BOOT: begin
                    state <= REQ;
                    if (redirect_i) begin
                        pc_q <= word_align(redirect_pc_i);
                    end
                end
                REQ: begin
                    if (fire) begin
                        state    <= WAIT;
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        kill_q   <= redirect_i;
                    end
                end
                WAIT: begin
                    if (resp) begin
                        state  <= REQ;
                        kill_q <= 1'b0;
                    end else if (redirect_i) begin
                        kill_q <= 1'b1;
                    end
                    if (load) begin
                        if_inst_o  <= imem_rdata_i;
                        if_pc_o    <= req_pc_q;
                        if_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase

            // Redirect overrides the sequential PC and flushes the output slot.
            if (redirect_i && state != BOOT) begin
                pc_q       <= word_align(redirect_pc_i);
                if_valid_o <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl with hand-computed expectations.
`default_nettype none

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic        if_ready_i;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_inst_o     (if_inst_o),
        .if_pc_o       (if_pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic vec_t mk(logic gnt, logic rv, logic [31:0] rdata, logic ready,
                                logic redir, logic [31:0] rpc, logic req,
                                logic [31:0] addr, logic valid, logic [31:0] inst,
                                logic [31:0] pc);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ready = ready;
        v.redir = redir; v.rpc = rpc; v.req = req; v.addr = addr;
        v.valid = valid; v.inst = inst; v.pc = pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic ready, input logic redir, input logic [31:0] rpc);
        imem_gnt_i    = gnt;
        imem_rvalid_i = rv;
        imem_rdata_i  = rdata;
        if_ready_i    = ready;
        redirect_i    = redir;
        redirect_pc_i = rpc;
    endtask

    task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] inst, input logic [31:0] pc);
        chk({tag, " req"},   {31'd0, imem_req_o}, {31'd0, req});
        chk({tag, " addr"},  imem_addr_o, addr);
        chk({tag, " valid"}, {31'd0, if_valid_o}, {31'd0, valid});
        chk({tag, " inst"},  if_inst_o, inst);
        chk({tag, " pc"},    if_pc_o, pc);
    endtask

    initial begin
        //            gnt rv rdata          rdy rd rpc            | req addr          vld inst           pc
        // Straight-line fetch, one instruction per two cycles
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          0, NOP,           32'h0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, NOP,           32'h0));
        vecs.push_back(mk(0, 1, 32'hA000_0000,  1, 0, 32'h0,          0, 32'h0,          0, NOP,           32'h0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,          1, 32'hA000_0000, 32'h0));
        vecs.push_back(mk(0, 1, 32'hA000_0001,  1, 0, 32'h0,          0, 32'h0,          0, 32'hA000_0000, 32'h0));
        // Stall: slot held, no request while ready=0
        vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h8,          1, 32'hA000_0001, 32'h4));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1, 0, 32'h0,      0, 0, 32'h0,          0, 32'h8,          1, 32'hA000_0001, 32'h4));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8,          1, 32'hA000_0001, 32'h4));
        // Redirect in WAIT; late response is killed
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0000_0100,  0, 32'h0,          0, 32'hA000_0001, 32'h4));
        vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0,          0, 32'hA000_0001, 32'h4));
        vecs.push_back(mk(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          0, 32'h0,          0, 32'hA000_0001, 32'h4));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,        0, 32'hA000_0001, 32'h4));
        vecs.push_back(mk(0, 1, 32'hB000_0000,  1, 0, 32'h0,          0, 32'h0,          0, 32'hA000_0001, 32'h4));
        // Redirect coincident with grant: granted fetch is stale, target aligned
        vecs.push_back(mk(1, 0, 32'h0,          1, 1, 32'h0000_0203,  1, 32'h104,        1, 32'hB000_0000, 32'h100));
        vecs.push_back(mk(0, 1, 32'h57A1_E000,  1, 0, 32'h0,          0, 32'h0,          0, 32'hB000_0000, 32'h100));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h200,        0, 32'hB000_0000, 32'h100));
        vecs.push_back(mk(0, 1, 32'hC000_0000,  1, 0, 32'h0,          0, 32'h0,          0, 32'hB000_0000, 32'h100));
        // Redirect with rvalid while slot valid: flush, stray word ignored
        vecs.push_back(mk(0, 1, 32'hEEEE_EEEE,  0, 1, 32'h0000_0300,  0, 32'h204,        1, 32'hC000_0000, 32'h200));
        vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h300,        0, 32'hC000_0000, 32'h200));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h300,        0, 32'hC000_0000, 32'h200));
        vecs.push_back(mk(0, 1, 32'hD000_0000,  1, 0, 32'h0,          0, 32'h0,          0, 32'hC000_0000, 32'h200));
        vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h304,        1, 32'hD000_0000, 32'h300));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'h304,        0, 32'hD000_0000, 32'h300));
        // PC wraps from the top word to zero
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFF,  0, 32'h0,          0, 32'hD000_0000, 32'h300));
        vecs.push_back(mk(0, 1, 32'h1111_1111,  1, 0, 32'h0,          0, 32'h0,          0, 32'hD000_0000, 32'h300));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'hD000_0000, 32'h300));
        vecs.push_back(mk(0, 1, 32'hE000_0000,  1, 0, 32'h0,          0, 32'h0,          0, 32'hD000_0000, 32'h300));
        vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'hE000_0000, 32'hFFFF_FFFC));

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_outs("reset", 0, 32'h0, 0, NOP, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].gnt, vecs[i].rv, vecs[i].rdata, vecs[i].ready,
                  vecs[i].redir, vecs[i].rpc);
            #1 check_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                          vecs[i].valid, vecs[i].inst, vecs[i].pc);
        end

        // Async reset in the middle of an outstanding fetch
        @(negedge clk);
        drive(1, 0, 32'h0, 1, 0, 32'h0);
        #1 check_outs("rst_pre", 1, 32'h0, 1, 32'hE000_0000, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        rst_n = 1'b0;
        #1 check_outs("rst_mid", 0, 32'h0, 0, NOP, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1, 32'hBAD0_BAD0, 1, 0, 32'h0);
        #1 check_outs("rst_boot", 0, 32'h0, 0, NOP, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        #1 check_outs("rst_req", 1, 32'h0, 0, NOP, 32'h0);
        @(negedge clk);
        #1 check_outs("rst_hold", 1, 32'h0, 0, NOP, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
